// File: rtl/serializador.sv
// serializador: MSB-first parallel-to-serial transmitter with per-bit DK flags,
// a one-word holding buffer for gapless streaming, and a first-bit frame strobe.
module serializador #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in,
    input  logic [BITS-1:0] in_DK,
    output logic            data,
    output logic            DK,
    output logic            frame,
    output logic            busy
);
    localparam int CW = $clog2(BITS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] sh_q, sh_d, shk_q, shk_d, hold_q, hold_d, holdk_q, holdk_d;
    logic            hold_full_q, hold_full_d, data_q, data_d, dk_q, dk_d, frame_q, frame_d;
    logic            acc, last, load, from_hold;
    logic [BITS-1:0] ld_w, ld_k;

    assign in_ready = !hold_full_q && !reset;
    assign acc      = in_valid && in_ready;
    assign last     = cnt_q == CW'(BITS - 1);
    assign data     = data_q;
    assign DK       = dk_q;
    assign frame    = frame_q;
    assign busy     = state_q == SHIFT;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        shk_d       = shk_q;
        hold_d      = hold_q;
        holdk_d     = holdk_q;
        hold_full_d = hold_full_q;
        data_d      = data_q;
        dk_d        = dk_q;
        frame_d     = frame_q;
        // The held word takes priority over a fresh offer at a word boundary.
        from_hold   = state_q == SHIFT && last && hold_full_q;
        load        = from_hold || (acc && (state_q == IDLE || last));
        ld_w        = from_hold ? hold_q : in;
        ld_k        = from_hold ? holdk_q : in_DK;
        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            data_d  = ld_w[BITS-1];
            dk_d    = ld_k[BITS-1];
            frame_d = 1'b1;
            sh_d    = ld_w << 1;
            shk_d   = ld_k << 1;
            if (from_hold) hold_full_d = 1'b0;
        end else if (state_q == SHIFT && last) begin
            state_d = IDLE;
            cnt_d   = '0;
            data_d  = 1'b0;
            dk_d    = 1'b0;
            frame_d = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d   = cnt_q + 1'b1;
            data_d  = sh_q[BITS-1];
            dk_d    = shk_q[BITS-1];
            frame_d = 1'b0;
            sh_d    = sh_q << 1;
            shk_d   = shk_q << 1;
            if (acc) begin
                hold_d      = in;
                holdk_d     = in_DK;
                hold_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            shk_q       <= '0;
            hold_q      <= '0;
            holdk_q     <= '0;
            hold_full_q <= 1'b0;
            data_q      <= 1'b0;
            dk_q        <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            shk_q       <= shk_d;
            hold_q      <= hold_d;
            holdk_q     <= holdk_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            dk_q        <= dk_d;
            frame_q     <= frame_d;
        end
    end
endmodule

// File: tb/tb_serializador.sv
// tb_serializador: random and directed traffic checked bit-by-bit against a word-queue model.
module tb_serializador;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] din = '0;
    logic [7:0] din_dk = '0;
    logic       data, DK, frame, busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] pend[$];
    logic [7:0]  cur_w = '0, cur_k = '0;
    int          cur_left = 0;

    serializador #(.BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in(din), .in_DK(din_dk), .data(data), .DK(DK), .frame(frame), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] w, input logic [7:0] k, output logic a);
        logic ed, ek, ef;
        in_valid = v;
        din      = w;
        din_dk   = k;
        @(negedge clk);
        ed = 1'b0;
        ek = 1'b0;
        ef = 1'b0;
        if (cur_left > 0) begin
            ed = cur_w[cur_left-1];
            ek = cur_k[cur_left-1];
            ef = cur_left == 8;
        end
        chk("in_ready", in_ready, pend.size() == 0);
        chk("data", data, ed);
        chk("DK", DK, ek);
        chk("frame", frame, ef);
        chk("busy", busy, cur_left > 0);
        a = v && pend.size() == 0;
        @(posedge clk);
        if (cur_left <= 1) begin
            if (pend.size() > 0) begin
                {cur_w, cur_k} = pend.pop_front();
                cur_left = 8;
            end else if (a) begin
                {cur_w, cur_k} = {w, k};
                cur_left = 8;
            end else cur_left = 0;
        end else begin
            cur_left--;
            if (a) pend.push_back({w, k});
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, $urandom, $urandom, a);
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] k);
        logic a;
        int   t;
        a = 1'b0;
        t = 0;
        while (!a && t < 40) begin
            cyc(1'b1, w, k, a);
            t++;
        end
        if (!a) chk("send_timeout", 0, 1);
    endtask

    task automatic rst_mid();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_data", data, 0);
        chk("rst_DK", DK, 0);
        chk("rst_frame", frame, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        pend.delete();
        cur_left = 0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic a;
        #2;
        chk("init_data", data, 0);
        chk("init_busy", busy, 0);
        chk("init_in_ready", in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        send(8'hA5, 8'h01);
        idle(10);
        send(8'hFF, 8'h0F);
        send(8'h00, 8'hF0);
        send(8'h81, 8'h81);
        idle(20);
        send(8'h12, 8'h34);
        idle(7);
        cyc(1'b1, 8'h3C, 8'h55, a);
        chk("bypass_acc", a, 1);
        idle(12);
        send(8'hC3, 8'hAA);
        send(8'h99, 8'h66);
        idle(3);
        rst_mid();
        send(8'h5A, 8'h0F);
        idle(12);
        for (int p = 0; p < 12; p++) begin
            int pv;
            pv = $urandom_range(100, 10);
            for (int i = 0; i < 200; i++)
                cyc($urandom_range(99, 0) < pv, $urandom, $urandom, a);
            if (p == 5) rst_mid();
        end
        idle(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
